// File: rtl/vproc_div_iter.sv
// vproc_div_iter: iterative radix-2 restoring divider for the vector lanes.
// Optional: define VPROC_DIV_EARLY_OUT_EN to retire special cases on accept.
module vproc_div_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             async_rst_i,
  input  logic             kill_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_signed_i,
  input  logic             in_mod_i,
  input  logic [WIDTH-1:0] in_op1_i,
  input  logic [WIDTH-1:0] in_op2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

  state_t state_q, state_d, acc_state;

  logic [WIDTH-1:0] rem_q, quot_q, dvs_q, op1_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mod_q, qneg_q, rneg_q, dz_q, ovf_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] res_q;
  logic [TAG_W-1:0] res_tag_q;
  logic             valid_q;

  logic             accept;
  logic             op1_neg, op2_neg;
  logic [WIDTH-1:0] op1_abs, op2_abs;
  logic             dz_in, ovf_in;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] q_fix, r_fix, fix_res;

  assign in_ready_o = ~kill_i &
    ((state_q == IDLE) | ((state_q == DONE) & res_ready_i));
  assign accept = in_valid_i & in_ready_o;

  assign op1_neg = in_signed_i & in_op1_i[WIDTH-1];
  assign op2_neg = in_signed_i & in_op2_i[WIDTH-1];
  assign op1_abs = op1_neg ? (~in_op1_i + 1'b1) : in_op1_i;
  assign op2_abs = op2_neg ? (~in_op2_i + 1'b1) : in_op2_i;

  assign dz_in  = (in_op2_i == '0);
  assign ovf_in = in_signed_i & (in_op1_i == MIN) & (&in_op2_i);

  // Widened by one bit so the trial subtract's borrow lands in the MSB.
  assign rem_sh = {rem_q, quot_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

`ifdef VPROC_DIV_EARLY_OUT_EN
  logic             early;
  logic [WIDTH-1:0] early_res;

  assign early = dz_in | ovf_in;
  assign early_res = dz_in ?
    (in_mod_i ? in_op1_i : '1) :
    (in_mod_i ? '0 : in_op1_i);
  assign acc_state = early ? DONE : DIV;
`else
  assign acc_state = DIV;
`endif

  // Sign fix-up and special-case override of the raw magnitudes.
  always_comb begin
    q_fix = qneg_q ? (~quot_q + 1'b1) : quot_q;
    r_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;
    fix_res = mod_q ? r_fix : q_fix;
    if (dz_q) begin
      fix_res = mod_q ? op1_q : '1;
    end else if (ovf_q) begin
      fix_res = mod_q ? '0 : op1_q;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; kill overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = acc_state;
      DIV:  if (cnt_q == LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        if (accept)           state_d = acc_state;
        else if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk_i or posedge async_rst_i) begin
    if (async_rst_i) begin
      rem_q     <= '0;
      quot_q    <= '0;
      dvs_q     <= '0;
      op1_q     <= '0;
      cnt_q     <= '0;
      mod_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      tag_q     <= '0;
      res_q     <= '0;
      res_tag_q <= '0;
      valid_q   <= 1'b0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else begin
      if (valid_q & res_ready_i) valid_q <= 1'b0;
      if (accept) begin
        rem_q  <= '0;
        quot_q <= op1_abs;
        dvs_q  <= op2_abs;
        op1_q  <= in_op1_i;
        cnt_q  <= '0;
        mod_q  <= in_mod_i;
        qneg_q <= op1_neg ^ op2_neg;
        rneg_q <= op1_neg;
        dz_q   <= dz_in;
        ovf_q  <= ovf_in;
        tag_q  <= in_tag_i;
`ifdef VPROC_DIV_EARLY_OUT_EN
        if (early) begin
          res_q     <= early_res;
          res_tag_q <= in_tag_i;
          valid_q   <= 1'b1;
        end
`endif
      end
      case (state_q)
        DIV: begin
          cnt_q <= cnt_q + 1'b1;
          if (!diff[WIDTH]) begin
            rem_q  <= diff[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q  <= rem_sh[WIDTH-1:0];
            quot_q <= {quot_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          res_q     <= fix_res;
          res_tag_q <= tag_q;
          valid_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid_o = valid_q;
  assign res_o       = res_q;
  assign res_tag_o   = res_tag_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_vproc_div_iter.sv
// tb_vproc_div_iter: randomized and directed checks of vproc_div_iter
// against an arithmetic reference model.
module tb_vproc_div_iter;

  localparam int W = 32;
  localparam int T = 4;

  logic         clk_i = 1'b0;
  logic         async_rst_i;
  logic         kill_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic         in_signed_i;
  logic         in_mod_i;
  logic [W-1:0] in_op1_i;
  logic [W-1:0] in_op2_i;
  logic [T-1:0] in_tag_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [W-1:0] res_o;
  logic [T-1:0] res_tag_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  vproc_div_iter #(.WIDTH(W), .TAG_W(T)) dut (
    .clk_i(clk_i),
    .async_rst_i(async_rst_i),
    .kill_i(kill_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_signed_i(in_signed_i),
    .in_mod_i(in_mod_i),
    .in_op1_i(in_op1_i),
    .in_op2_i(in_op2_i),
    .in_tag_i(in_tag_i),
    .res_valid_o(res_valid_o),
    .res_ready_i(res_ready_i),
    .res_o(res_o),
    .res_tag_o(res_tag_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_div(input bit s, input bit m,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint sa, sb;
    if (b == 0) return m ? a : '1;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return m ? W'(sa % sb) : W'(sa / sb);
    end
    return m ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input bit s, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    bit special;
    special = (b == 0) || (s && a == 32'h8000_0000 && b == '1);
`ifdef VPROC_DIV_EARLY_OUT_EN
    return special ? 0 : W + 1;
`else
    return special ? W + 1 : W + 1;
`endif
  endfunction

  task automatic issue(input bit s, input bit m, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [T-1:0] t);
    in_signed_i = s;
    in_mod_i    = m;
    in_op1_i    = a;
    in_op2_i    = b;
    in_tag_i    = t;
    in_valid_i  = 1'b1;
  endtask

  // Called #1 after the accepting edge; counts edges until valid.
  task automatic wait_res(input string tag, input logic [W-1:0] exp,
                          input logic [T-1:0] et, input int elat);
    int lat = 0;
    while (!res_valid_o && lat < 200) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_res"}, res_o, exp);
    check({tag, "_tag"}, res_tag_o, et);
  endtask

  task automatic retire(input string tag);
    res_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    res_ready_i = 1'b0;
    check({tag, "_vclr"}, res_valid_o, 1'b0);
    check({tag, "_idle"}, busy_o, 1'b0);
  endtask

  task automatic run(input string tag, input bit s, input bit m,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [T-1:0] t);
    check({tag, "_rdy"}, in_ready_o, 1'b1);
    issue(s, m, a, b, t);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    wait_res(tag, ref_div(s, m, a, b), t, ref_lat(s, a, b));
    retire(tag);
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
      if (res_valid_o || busy_o) seen++;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    logic [W-1:0] ea, eb;
    async_rst_i = 1'b1;
    kill_i      = 1'b0;
    in_valid_i  = 1'b0;
    res_ready_i = 1'b0;
    issue(0, 0, '0, '0, '0);
    in_valid_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_valid", res_valid_o, 1'b0);
    check("rst_res", res_o, '0);
    check("rst_tag", res_tag_o, '0);
    check("rst_busy", busy_o, 1'b0);
    async_rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    run("sdiv", 1, 0, 32'hFFFF_FFF9, 32'd2, 4'd3);
    run("srem", 1, 1, 32'hFFFF_FFF9, 32'd2, 4'd3);
    run("udiv", 0, 0, 32'hFFFF_FFF9, 32'd2, 4'd1);
    run("urem", 0, 1, 32'hFFFF_FFF9, 32'd2, 4'd2);
    run("dz_q", 1, 0, 32'h1234_5678, 32'd0, 4'd4);
    run("dz_r", 0, 1, 32'h1234_5678, 32'd0, 4'd5);
    run("ov_q", 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6);
    run("ov_r", 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7);

    // Backpressure, then back-to-back accept on the retiring cycle.
    issue(1, 0, 32'd1000, 32'hFFFF_FFF9, 4'd8);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    ea = ref_div(1, 0, 32'd1000, 32'hFFFF_FFF9);
    wait_res("bp", ea, 4'd8, W + 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      check("bp_hold_res", res_o, ea);
      check("bp_hold_tag", res_tag_o, 4'd8);
      check("bp_hold_rdy", in_ready_o, 1'b0);
    end
    issue(0, 1, 32'hDEAD_BEEF, 32'd1234, 4'd9);
    res_ready_i = 1'b1;
    #1;
    check("b2b_rdy", in_ready_o, 1'b1);
    @(posedge clk_i);
    #1;
    in_valid_i  = 1'b0;
    res_ready_i = 1'b0;
    check("b2b_busy", busy_o, 1'b1);
    wait_res("b2b", ref_div(0, 1, 32'hDEAD_BEEF, 32'd1234), 4'd9, W + 1);
    retire("b2b");

    // Kill mid-iteration with a coinciding request.
    issue(1, 0, 32'd100, 32'd7, 4'd10);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    kill_i = 1'b1;
    issue(0, 0, 32'd55, 32'd5, 4'd11);
    #1;
    check("kill_rdy", in_ready_o, 1'b0);
    @(posedge clk_i);
    #1;
    kill_i     = 1'b0;
    in_valid_i = 1'b0;
    check("kill_busy", busy_o, 1'b0);
    check("kill_valid", res_valid_o, 1'b0);
    expect_quiet("kill_quiet", 40);
    run("post_kill", 1, 0, 32'hFFFF_FF00, 32'd3, 4'd12);

    // Asynchronous reset mid-iteration.
    issue(0, 0, 32'd999, 32'd10, 4'd13);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    async_rst_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_valid", res_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    async_rst_i = 1'b0;
    expect_quiet("arst_quiet", 40);
    run("post_arst", 0, 1, 32'd999, 32'd10, 4'd14);

    // Random operations, with a bias toward edge operands.
    for (int i = 0; i < 30; i++) begin
      bit s, m;
      int sel;
      s = 1'($urandom);
      m = 1'($urandom);
      ea = $urandom;
      eb = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 0) eb = '0;
      if (sel == 1) begin
        ea = 32'h8000_0000;
        eb = '1;
      end
      if (sel == 2) eb = W'($urandom_range(1, 20));
      if (sel == 3) eb = eb >> $urandom_range(0, 31);
      run("rand", s, m, ea, eb, T'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
